// File: rtl/autosel_pkg.sv
// Shared types and constants for the autosel UART transmitter.
package autosel_pkg;

    localparam int UART_DATA_W    = 8;
    localparam int UART_STOP_BITS = 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

endpackage

// File: rtl/autosel_uart_tx_if.sv
// Valid/ready byte handshake between the autosel control logic and the UART transmitter.
interface autosel_uart_tx_if import autosel_pkg::*; ();

    logic [UART_DATA_W-1:0] data_in;
    logic                   data_valid;
    logic                   data_ready;

    modport master (output data_in, output data_valid, input data_ready);
    modport slave  (input data_in, input data_valid, output data_ready);

endinterface

// File: rtl/autosel_uart_fifo.sv
// Synchronous FIFO with occupancy count; the count is the only source of full/empty.
module autosel_uart_fifo import autosel_pkg::*; #(
    parameter int DEPTH = 4,
    parameter int WIDTH = UART_DATA_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push, do_pop;

    assign full    = (level_q == LVL_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: every variable gets a default before any branch so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // NOTE: storage is not reset; level_q guarantees stale entries are never read.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/autosel_uart_tx.sv
// Buffered UART transmitter (8N1; 8E1 when AUTOSEL_UART_PARITY_EN is defined) feeding uo_out[4].
module autosel_uart_tx import autosel_pkg::*; #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    autosel_uart_tx_if.slave              bus,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(UART_DATA_W);

    uart_state_t            state_q, state_d;
    logic [BAUD_W-1:0]      baud_q, baud_d;
    logic [BIT_W-1:0]       bit_q, bit_d;
    logic [UART_DATA_W-1:0] shift_q, shift_d;
    logic                   baud_tc;
    logic                   fifo_pop, fifo_full, fifo_empty;
    logic [UART_DATA_W-1:0] fifo_rdata;
`ifdef AUTOSEL_UART_PARITY_EN
    logic                   parity_q, parity_d;
`endif

    autosel_uart_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (bus.data_valid),
        .pop   (fifo_pop),
        .wdata (bus.data_in),
        .rdata (fifo_rdata),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.data_ready = !fifo_full;
    assign busy           = (state_q != IDLE) || (fifo_level != '0);
    assign baud_tc        = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        fifo_pop = 1'b0;
`ifdef AUTOSEL_UART_PARITY_EN
        parity_d = parity_q;
`endif
        if (state_q != IDLE) baud_d = baud_tc ? '0 : baud_q + 1'b1;

        // Loading from IDLE and from the end of STOP share one path so frames stay contiguous.
        if ((state_q == IDLE || (state_q == STOP && baud_tc &&
             bit_q == BIT_W'(UART_STOP_BITS - 1))) && !fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rdata;
            state_d  = START;
            baud_d   = '0;
            bit_d    = '0;
`ifdef AUTOSEL_UART_PARITY_EN
            parity_d = ^fifo_rdata;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    baud_d = '0;
                end
                START: begin
                    if (baud_tc) begin
                        state_d = DATA;
                        bit_d   = '0;
                    end
                end
                DATA: begin
                    if (baud_tc) begin
                        shift_d = shift_q >> 1;
                        if (bit_q == BIT_W'(UART_DATA_W - 1)) begin
                            bit_d = '0;
`ifdef AUTOSEL_UART_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end
                end
`ifdef AUTOSEL_UART_PARITY_EN
                PARITY: begin
                    if (baud_tc) begin
                        state_d = STOP;
                        bit_d   = '0;
                    end
                end
`endif
                STOP: begin
                    if (baud_tc) begin
                        if (bit_q == BIT_W'(UART_STOP_BITS - 1)) begin
                            state_d = IDLE;
                            bit_d   = '0;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        tx = 1'b1;
        case (state_q)
            START:   tx = 1'b0;
            DATA:    tx = shift_q[0];
`ifdef AUTOSEL_UART_PARITY_EN
            PARITY:  tx = parity_q;
`endif
            default: tx = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
`ifdef AUTOSEL_UART_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
`ifdef AUTOSEL_UART_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_autosel_uart_tx.sv
// Bench for autosel_uart_tx: per-cycle comparison against a frame-timing model built from accept times.
module tb_autosel_uart_tx;

    localparam int C     = 4;
    localparam int DEPTH = 4;
`ifdef AUTOSEL_UART_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int F = NBITS * C;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_level;

    autosel_uart_tx_if bus ();

    autosel_uart_tx #(
        .CLKS_PER_BIT (C),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .tx         (tx),
        .busy       (busy),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    // Model: each accepted byte starts its frame at max(accept edge + 1, previous start + F).
    logic [7:0] bytes_q[$];
    int         acc_t[$];
    int         st_t[$];
    int         cyc      = 0;
    int         checks   = 0;
    int         errors   = 0;
    logic       accepted = 1'b0;

    function automatic int model_level(int e);
        int n = 0;
        foreach (acc_t[i]) if (acc_t[i] <= e) n++;
        foreach (st_t[i])  if (st_t[i] <= e) n--;
        return n;
    endfunction

    function automatic int frame_at(int e);
        foreach (st_t[i]) if (st_t[i] <= e && e < st_t[i] + F) return i;
        return -1;
    endfunction

    function automatic logic model_tx(int e);
        int i, b;
        i = frame_at(e);
        if (i < 0) return 1'b1;
        b = (e - st_t[i]) / C;
        if (b == 0) return 1'b0;
        if (b <= 8) return bytes_q[i][b-1];
        if (NBITS == 11 && b == 9) return ^bytes_q[i];
        return 1'b1;
    endfunction

    task automatic check_outputs();
        logic       e_tx, e_busy, e_rdy;
        logic [2:0] e_lvl;
        int         lvl;
        lvl    = model_level(cyc);
        e_lvl  = 3'(lvl);
        e_rdy  = (lvl < DEPTH);
        e_tx   = model_tx(cyc);
        e_busy = (lvl != 0) || (frame_at(cyc) >= 0);
        checks++;
        assert (tx === e_tx) else begin
            errors++; $error("FAIL tx cyc=%0d observed=%b expected=%b", cyc, tx, e_tx);
        end
        checks++;
        assert (busy === e_busy) else begin
            errors++; $error("FAIL busy cyc=%0d observed=%b expected=%b", cyc, busy, e_busy);
        end
        checks++;
        assert (bus.data_ready === e_rdy) else begin
            errors++; $error("FAIL data_ready cyc=%0d observed=%b expected=%b", cyc, bus.data_ready, e_rdy);
        end
        checks++;
        assert (fifo_level === e_lvl) else begin
            errors++; $error("FAIL fifo_level cyc=%0d observed=%0d expected=%0d", cyc, fifo_level, e_lvl);
        end
    endtask

    task automatic step();
        logic rdy;
        int   st;
        rdy = (model_level(cyc) < DEPTH);
        @(posedge clk);
        cyc++;
        accepted = 1'b0;
        if (!rst_n) begin
            bytes_q.delete();
            acc_t.delete();
            st_t.delete();
        end else if (bus.data_valid && rdy) begin
            st = cyc + 1;
            if (st_t.size() > 0 && st_t[st_t.size()-1] + F > st) st = st_t[st_t.size()-1] + F;
            bytes_q.push_back(bus.data_in);
            acc_t.push_back(cyc);
            st_t.push_back(st);
            accepted = 1'b1;
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(int n);
        bus.data_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    // Offers a byte and holds it until the model says it was taken.
    task automatic send(logic [7:0] b);
        int tries = 0;
        bus.data_valid = 1'b1;
        bus.data_in    = b;
        do begin
            step();
            tries++;
        end while (!accepted && tries < 500);
        checks++;
        assert (accepted) else begin
            errors++; $error("FAIL send_timeout byte=%h observed=not_accepted expected=accepted", b);
        end
        bus.data_valid = 1'b0;
        bus.data_in    = 8'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        bus.data_valid = 1'b0;
        while ((model_level(cyc) != 0 || frame_at(cyc) >= 0) && n < 5000) begin
            step();
            n++;
        end
        idle(3);
    endtask

    initial begin
        int st0;
        rst_n          = 1'b0;
        bus.data_valid = 1'b1;
        bus.data_in    = 8'hFF;
        for (int i = 0; i < 3; i++) step();
        rst_n = 1'b1;
        idle(3);

        // Single byte from idle.
        send(8'hA5);
        drain();

        // Burst that fills the FIFO; 0x06 is refused on the full cycle and re-offered.
        for (int b = 1; b <= 6; b++) send(8'(b));
        drain();

        send(8'h07);
        drain();
        send(8'h03);
        drain();

        // Reset during data bit 3 of 0x3C with two bytes queued behind it.
        send(8'h3C);
        st0 = st_t[st_t.size()-1];
        send(8'h11);
        send(8'h22);
        while (cyc < st0 + 4 * C + 1 && cyc < st0 + 200) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        idle(3 * F);

        // Random bytes with random gaps, including back-to-back bursts.
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 2) != 0) idle($urandom_range(0, 50));
            send(8'($urandom));
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
